microwave_controller: RTL and testbench
=======================================

Name: microwave_controller

Overview:
Control FSM that sequences the 3-digit BCD countdown timer (units-of-seconds, tens-of-seconds, minutes). It shifts keypad digits into the timer and generates the one-cycle 1 Hz enable pulses that make the timer count down. It also drives the magnetron and the done indicator, and handles start, stop/cancel and door-open events. It sits between keypad/button front-end (already synchronised and debounced, single-cycle pulses) and the timer instance.

Parameters:
TICK_DIV, 50000000, clk cycles per timer decrement (1 s at 50 MHz); >= 2
DONE_CYCLES, 150000000, clk cycles the done indicator stays high before returning to IDLE; >= 1

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle pulse, key_digit valid
key_digit  input  4  keypad code; 0-9 valid BCD, 10-15 ignored
start  input  1  one-cycle start pulse
stop  input  1  one-cycle stop/cancel pulse
door_closed  input  1  level, 1 = door closed
timer_zero  input  1  timer zero flag (all digits 0)
timer_clearn  output  1  timer clear, active-low
timer_loadn  output  1  timer shift-load strobe, active-low, one cycle per digit
timer_enable  output  1  timer decrement strobe, one cycle per tick
timer_bcd  output  4  digit presented to timer bcd input
mag_on  output  1  magnetron drive
cooking  output  1  state == COOKING
paused  output  1  state == PAUSED
done  output  1  state == DONE

Behaviour:
- All outputs registered. State change and output update occur one clk after the causing input.
- Reset (clear high, async):
  - state = IDLE, prescaler = 0, done counter = 0.
  - timer_clearn = 0, timer_loadn = 1, timer_enable = 0, timer_bcd = 0.
  - mag_on, cooking, paused, done = 0.
  - timer_clearn returns to 1 on the first clk after clear deasserts, so the timer is cleared.
  - Reset mid-COOKING stops the magnetron immediately.
- States: IDLE, COOKING, PAUSED, DONE.
- Per-cycle event priority: stop > door open > start > key_valid.
- IDLE:
  - key_valid with key_digit <= 9: timer_bcd = key_digit and timer_loadn = 0 for exactly one cycle. The timer shifts the digit in (min <- tens <- units <- digit). The oldest minute digit is dropped. No limit on entry count.
  - key_digit > 9: ignored.
  - stop: timer_clearn = 0 for one cycle; stay IDLE.
  - start with door_closed = 1 and timer_zero = 0: go to COOKING. A key_valid in the same cycle is dropped.
  - start with door open or timer_zero = 1: ignored.
- COOKING:
  - mag_on = 1 and cooking = 1.
  - Prescaler is cleared on entry and increments every cycle, wrapping at TICK_DIV-1.
  - timer_enable pulses high for one cycle on COOKING cycles TICK_DIV, 2*TICK_DIV, ..., counting the first COOKING cycle as 1.
  - timer_enable is suppressed whenever timer_zero = 1.
  - timer_zero = 1: go to DONE.
  - stop or door_closed = 0: go to PAUSED. No pulse is issued in the transition cycle.
  - key_valid: ignored.
- PAUSED:
  - mag_on = 0, paused = 1. Timer digits are held (timer_enable = 0).
  - start with door_closed = 1: go to COOKING, prescaler restarts at 0.
  - stop: timer_clearn = 0 for one cycle, then go to IDLE.
  - key_valid: ignored.
- DONE:
  - done = 1, mag_on = 0.
  - Done counter runs DONE_CYCLES cycles, then go to IDLE with done = 0.
  - stop or door_closed = 0 exits to IDLE early.
  - start and keys: ignored.
- timer_loadn and timer_clearn are never low in the same cycle. timer_enable is never high outside COOKING.
- Expected size: 150-250 lines.

Test Plan:
- Reset: hold clear 3 cycles, release -> timer_clearn 0 during reset and 1 the cycle after, all other outputs at reset values, state IDLE.
- Entry: keys 1, 2, 3 in IDLE -> three single-cycle timer_loadn lows with timer_bcd = 1, 2, 3; timer reads 1:23. Key code 12 -> no loadn pulse.
- Countdown with TICK_DIV = 4, time 0:05, door closed, start:
  - cooking/mag_on high next cycle.
  - Exactly 5 timer_enable pulses, 4 cycles apart.
  - Timer reaches 0:00, then DONE; done high for DONE_CYCLES (set 8), then IDLE.
  - No enable pulse occurs after zero.
- Pause/resume at 0:30:
  - Drop door_closed mid-count -> PAUSED next cycle, mag_on 0, digits frozen.
  - Restore door, pulse start -> COOKING resumes; first enable arrives TICK_DIV cycles later.
- Cancel: stop in PAUSED -> one-cycle timer_clearn low, timer reads 0:00, IDLE. Stop and start in the same IDLE cycle -> stop wins, no COOKING.
- Guards:
  - Start with door open -> stays IDLE.
  - Start with timer at 0:00 -> stays IDLE.
  - Key pulse during COOKING -> no loadn pulse.

Source files
------------

// File: rtl/microwave_controller_if.sv
// Microwave controller bus: keypad/button inputs, timer drive and status.
// master = controller side, slave = keypad front-end / timer / panel side.
interface microwave_controller_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       timer_zero;
  logic       timer_clearn;
  logic       timer_loadn;
  logic       timer_enable;
  logic [3:0] timer_bcd;
  logic       mag_on;
  logic       cooking;
  logic       paused;
  logic       done;

  modport master (
    input  key_valid, key_digit, start, stop,
    input  door_closed, timer_zero,
    output timer_clearn, timer_loadn, timer_enable,
    output timer_bcd, mag_on, cooking, paused, done
  );

  modport slave (
    output key_valid, key_digit, start, stop,
    output door_closed, timer_zero,
    input  timer_clearn, timer_loadn, timer_enable,
    input  timer_bcd, mag_on, cooking, paused, done
  );
endinterface

// File: rtl/microwave_controller.sv
// Microwave control FSM: keypad entry, 1 Hz countdown strobes, magnetron.
// Ports: clk, clear (async active-high), bus (master modport of the _if).
module microwave_controller #(
  parameter int TICK_DIV    = 50000000,
  parameter int DONE_CYCLES = 150000000
) (
  input logic                   clk,
  input logic                   clear,
  microwave_controller_if.master bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DONE_CYCLES + 1);

  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_PRE  = PW'(TICK_DIV - 2);
  localparam logic [DW-1:0] DC_LAST = DW'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COOKING,
    PAUSED,
    DONE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_dcnt;
  logic          r_clearn;
  logic          r_loadn;
  logic          r_enable;
  logic [3:0]    r_bcd;
  logic          r_mag;
  logic          r_cook;
  logic          r_pause;
  logic          r_done;

  logic w_key_ok;
  logic w_door_open;
  logic w_can_start;

  assign w_key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);
  assign w_door_open = !bus.door_closed;
  assign w_can_start = bus.start && bus.door_closed;

  assign bus.timer_clearn = r_clearn;
  assign bus.timer_loadn  = r_loadn;
  assign bus.timer_enable = r_enable;
  assign bus.timer_bcd    = r_bcd;
  assign bus.mag_on       = r_mag;
  assign bus.cooking      = r_cook;
  assign bus.paused       = r_pause;
  assign bus.done         = r_done;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state  <= IDLE;
      r_presc  <= '0;
      r_dcnt   <= '0;
      r_clearn <= 1'b0;
      r_loadn  <= 1'b1;
      r_enable <= 1'b0;
      r_bcd    <= 4'd0;
      r_mag    <= 1'b0;
      r_cook   <= 1'b0;
      r_pause  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_clearn <= 1'b1;
      r_loadn  <= 1'b1;
      r_enable <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.stop) begin
            r_clearn <= 1'b0;
          end else if (w_can_start && !bus.timer_zero) begin
            r_state <= COOKING;
            r_presc <= '0;
            r_mag   <= 1'b1;
            r_cook  <= 1'b1;
          end else if (w_key_ok) begin
            r_loadn <= 1'b0;
            r_bcd   <= bus.key_digit;
          end
        end
        COOKING: begin
          if (bus.stop || w_door_open) begin
            r_state <= PAUSED;
            r_mag   <= 1'b0;
            r_cook  <= 1'b0;
            r_pause <= 1'b1;
          end else if (bus.timer_zero) begin
            r_state <= DONE;
            r_dcnt  <= '0;
            r_mag   <= 1'b0;
            r_cook  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_presc <= (r_presc == PS_LAST) ? '0
                                            : r_presc + PW'(1);
            // Strobe is registered, so fire one count early to land
            // on cooking cycle TICK_DIV, 2*TICK_DIV, ...
            if (r_presc == PS_PRE) r_enable <= 1'b1;
          end
        end
        PAUSED: begin
          if (bus.stop) begin
            r_state  <= IDLE;
            r_clearn <= 1'b0;
            r_pause  <= 1'b0;
          end else if (w_can_start) begin
            r_state <= COOKING;
            r_presc <= '0;
            r_mag   <= 1'b1;
            r_cook  <= 1'b1;
            r_pause <= 1'b0;
          end
        end
        DONE: begin
          if (bus.stop || w_door_open ||
              r_dcnt == DC_LAST) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_mag   <= 1'b0;
          r_cook  <= 1'b0;
          r_pause <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with a behavioural BCD timer.
// TICK_DIV = 4, DONE_CYCLES = 8.
module tb_microwave_controller;

  logic clk = 1'b0;
  logic clear;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  microwave_controller_if u_if ();

  microwave_controller #(
    .TICK_DIV    (4),
    .DONE_CYCLES (8)
  ) u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (u_if.master)
  );

  bit [3:0] tm_m, tm_t, tm_u;
  wire [11:0] tm = {tm_m, tm_t, tm_u};

  assign u_if.timer_zero = (tm == 12'h000);

  always @(posedge clk) begin
    if (!u_if.timer_clearn) begin
      tm_m <= 4'd0;
      tm_t <= 4'd0;
      tm_u <= 4'd0;
    end else if (!u_if.timer_loadn) begin
      tm_m <= tm_t;
      tm_t <= tm_u;
      tm_u <= u_if.timer_bcd;
    end else if (u_if.timer_enable) begin
      if (tm_u != 4'd0) tm_u <= tm_u - 4'd1;
      else begin
        tm_u <= 4'd9;
        if (tm_t != 4'd0) tm_t <= tm_t - 4'd1;
        else begin
          tm_t <= 4'd5;
          tm_m <= tm_m - 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input bit load);
    u_if.key_valid = 1'b1;
    u_if.key_digit = d;
    tick();
    chk("key_loadn", u_if.timer_loadn, load ? 0 : 1);
    if (load) chk("key_bcd", u_if.timer_bcd, d);
    u_if.key_valid = 1'b0;
    tick();
    chk("key_loadn_rel", u_if.timer_loadn, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int n_en, en_bad, en_zero, first_done, done_len;
    int cook_len, load_low, mag_bad, first_en;

    clear            = 1'b1;
    u_if.key_valid   = 1'b0;
    u_if.key_digit   = 4'd0;
    u_if.start       = 1'b0;
    u_if.stop        = 1'b0;
    u_if.door_closed = 1'b1;

    // Reset
    repeat (3) tick();
    chk("rst_clearn", u_if.timer_clearn, 0);
    chk("rst_loadn", u_if.timer_loadn, 1);
    chk("rst_flags",
        {u_if.timer_enable, u_if.mag_on, u_if.cooking,
         u_if.paused, u_if.done}, 0);
    chk("rst_bcd", u_if.timer_bcd, 0);
    clear = 1'b0;
    tick();
    chk("rel_clearn", u_if.timer_clearn, 1);
    chk("rel_timer", tm, 12'h000);

    // Entry
    press(4'd1, 1);
    press(4'd2, 1);
    press(4'd3, 1);
    chk("entry_123", tm, 12'h123);
    press(4'd12, 0);
    chk("entry_bad_key", tm, 12'h123);

    // Stop and start together: stop wins
    u_if.stop  = 1'b1;
    u_if.start = 1'b1;
    tick();
    u_if.stop  = 1'b0;
    u_if.start = 1'b0;
    chk("ss_clearn", u_if.timer_clearn, 0);
    chk("ss_cooking", u_if.cooking, 0);
    tick();
    chk("ss_timer", tm, 12'h000);
    chk("ss_clearn_rel", u_if.timer_clearn, 1);

    // Start with timer at 0:00
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk("zero_start", u_if.cooking, 0);

    // Start with door open
    press(4'd5, 1);
    chk("entry_005", tm, 12'h005);
    u_if.door_closed = 1'b0;
    u_if.start       = 1'b1;
    tick();
    u_if.start       = 1'b0;
    chk("door_start", {u_if.cooking, u_if.mag_on}, 0);
    u_if.door_closed = 1'b1;
    tick();
    chk("door_start2", u_if.cooking, 0);

    // Countdown 0:05
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk("cd_cooking", u_if.cooking, 1);
    chk("cd_mag", u_if.mag_on, 1);
    n_en = 0; en_bad = 0; en_zero = 0; first_done = 0;
    done_len = 0; cook_len = 0; load_low = 0; mag_bad = 0;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      if (u_if.timer_enable) begin
        n_en++;
        if (cyc % 4 != 0) en_bad++;
        if (u_if.timer_zero) en_zero++;
      end
      if (u_if.cooking) cook_len++;
      if (!u_if.timer_loadn) load_low++;
      if (u_if.done) begin
        if (first_done == 0) first_done = cyc;
        done_len++;
        if (u_if.mag_on) mag_bad++;
      end
      if (cyc == 30)
        chk("cd_idle", {u_if.cooking, u_if.done, u_if.paused}, 0);
      u_if.key_valid = (cyc == 5);
      u_if.key_digit = 4'd7;
      tick();
    end
    u_if.key_valid = 1'b0;
    chk("cd_n_en", n_en, 5);
    chk("cd_en_pos", en_bad, 0);
    chk("cd_en_zero", en_zero, 0);
    chk("cd_cook_len", cook_len, 21);
    chk("cd_first_done", first_done, 22);
    chk("cd_done_len", done_len, 8);
    chk("cd_done_mag", mag_bad, 0);
    chk("cd_key_ignored", load_low, 0);
    chk("cd_timer", tm, 12'h000);

    // Pause / resume at 0:30
    press(4'd3, 1);
    press(4'd0, 1);
    chk("entry_030", tm, 12'h030);
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    n_en = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      if (u_if.timer_enable) n_en++;
      if (cyc == 7) u_if.door_closed = 1'b0;
      tick();
    end
    chk("pz_n_en", n_en, 1);
    chk("pz_paused", u_if.paused, 1);
    chk("pz_mag", {u_if.mag_on, u_if.cooking}, 0);
    chk("pz_no_pulse", u_if.timer_enable, 0);
    n_en = 0;
    repeat (5) begin
      tick();
      if (u_if.timer_enable) n_en++;
    end
    chk("pz_hold_en", n_en, 0);
    chk("pz_frozen", tm, 12'h029);
    u_if.door_closed = 1'b1;
    u_if.start       = 1'b1;
    tick();
    u_if.start       = 1'b0;
    chk("rs_state", {u_if.cooking, u_if.mag_on, u_if.paused}, 3'b110);
    first_en = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (u_if.timer_enable) begin
        first_en = cyc;
        break;
      end
      tick();
    end
    chk("rs_first_en", first_en, 4);
    tick();
    chk("rs_timer", tm, 12'h028);

    // Cancel from PAUSED
    u_if.door_closed = 1'b0;
    tick();
    chk("cx_paused", u_if.paused, 1);
    u_if.stop = 1'b1;
    tick();
    u_if.stop = 1'b0;
    chk("cx_clearn", u_if.timer_clearn, 0);
    chk("cx_loadn", u_if.timer_loadn, 1);
    chk("cx_paused_rel", u_if.paused, 0);
    u_if.door_closed = 1'b1;
    tick();
    chk("cx_clearn_rel", u_if.timer_clearn, 1);
    chk("cx_timer", tm, 12'h000);
    chk("cx_idle",
        {u_if.mag_on, u_if.cooking, u_if.paused, u_if.done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
